// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants and the decode bundle shared by the decoders and the ALU.
// Opcode/funct values are the standard MIPS encodings.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_CTR_ADD  = 4'b0000;
    localparam logic [3:0] ALU_CTR_SUB  = 4'b0001;
    localparam logic [3:0] ALU_CTR_SRAV = 4'b0011;
    localparam logic [3:0] ALU_CTR_SLLV = 4'b0100;
    localparam logic [3:0] ALU_CTR_SLL  = 4'b0101;
    localparam logic [3:0] ALU_CTR_SLT  = 4'b0111;
    localparam logic [3:0] ALU_CTR_AND  = 4'b1001;
    localparam logic [3:0] ALU_CTR_OR   = 4'b1010;
    localparam logic [3:0] ALU_CTR_SRA  = 4'b1011;
    localparam logic [3:0] ALU_CTR_NOR  = 4'b1100;
    localparam logic [3:0] ALU_CTR_XOR  = 4'b1101;
    localparam logic [3:0] ALU_CTR_SRLV = 4'b1110;
    localparam logic [3:0] ALU_CTR_SRL  = 4'b1111;

    typedef enum logic [1:0] {
        EXT_NONE,
        EXT_ZERO,
        EXT_SIGN
    } ext_mode_t;

    // Immediate is kept outside the bundle so its width can follow XLEN.
    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [4:0]  shamt;
        logic [25:0] instr_index;
        logic [3:0]  alu_ctr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic        illegal;
    } decode_bundle_t;

    localparam int DEC_BUNDLE_W = $bits(decode_bundle_t);

endpackage

// File: rtl/decode_logic.sv
// Combinational MIPS instruction decoder: instruction word -> control bundle,
// extended immediate and source-register usage flags. Zero latency, no state.
module decode_logic
    import mips_isa_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output decode_bundle_t  dec,
    output logic [XLEN-1:0] imm,
    output logic            uses_rs,
    output logic            uses_rt
);

    logic [5:0] opcode;
    logic [5:0] funct;
    ext_mode_t  ext;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        dec             = '0;
        dec.rs          = instr[25:21];
        dec.rt          = instr[20:16];
        dec.dst         = instr[20:16];
        dec.shamt       = instr[10:6];
        dec.instr_index = instr[25:0];
        dec.alu_src     = 1'b1;
        ext             = EXT_NONE;
        uses_rs         = 1'b1;
        uses_rt         = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec.dst       = instr[15:11];
                dec.alu_src   = 1'b0;
                dec.reg_write = 1'b1;
                uses_rt       = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: dec.alu_ctr = ALU_CTR_ADD;
                    FN_SUB:          dec.alu_ctr = ALU_CTR_SUB;
                    FN_SRAV:         dec.alu_ctr = ALU_CTR_SRAV;
                    FN_SLLV:         dec.alu_ctr = ALU_CTR_SLLV;
                    FN_SLT:          dec.alu_ctr = ALU_CTR_SLT;
                    FN_AND:          dec.alu_ctr = ALU_CTR_AND;
                    FN_OR:           dec.alu_ctr = ALU_CTR_OR;
                    FN_NOR:          dec.alu_ctr = ALU_CTR_NOR;
                    FN_XOR:          dec.alu_ctr = ALU_CTR_XOR;
                    FN_SRLV:         dec.alu_ctr = ALU_CTR_SRLV;
                    // Constant shifts take their amount from shamt, not rs.
                    FN_SLL: begin dec.alu_ctr = ALU_CTR_SLL; uses_rs = 1'b0; end
                    FN_SRL: begin dec.alu_ctr = ALU_CTR_SRL; uses_rs = 1'b0; end
                    FN_SRA: begin dec.alu_ctr = ALU_CTR_SRA; uses_rs = 1'b0; end
                    default: begin
                        dec.illegal   = 1'b1;
                        dec.reg_write = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin dec.alu_ctr = ALU_CTR_ADD; dec.reg_write = 1'b1; ext = EXT_SIGN; end
            OP_ANDI: begin dec.alu_ctr = ALU_CTR_AND; dec.reg_write = 1'b1; ext = EXT_ZERO; end
            OP_ORI:  begin dec.alu_ctr = ALU_CTR_OR;  dec.reg_write = 1'b1; ext = EXT_ZERO; end
            OP_XORI: begin dec.alu_ctr = ALU_CTR_XOR; dec.reg_write = 1'b1; ext = EXT_ZERO; end
            OP_LW: begin
                dec.alu_ctr   = ALU_CTR_ADD;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                ext           = EXT_SIGN;
            end
            OP_SW: begin
                dec.alu_ctr   = ALU_CTR_ADD;
                dec.mem_write = 1'b1;
                uses_rt       = 1'b1;
                ext           = EXT_SIGN;
            end
            OP_BEQ: begin
                dec.alu_ctr = ALU_CTR_SUB;
                dec.branch  = 1'b1;
                dec.alu_src = 1'b0;
                uses_rt     = 1'b1;
                ext         = EXT_SIGN;
            end
            OP_J: begin
                dec.jump = 1'b1;
                uses_rs  = 1'b0;
            end
            default: begin
                dec.illegal = 1'b1;
                dec.alu_src = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (ext)
            EXT_SIGN: imm = {{(XLEN-16){instr[15]}}, instr[15:0]};
            EXT_ZERO: imm = {{(XLEN-16){1'b0}}, instr[15:0]};
            default:  imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// IF/ID->EX pipeline register around decode_logic, 1-cycle latency from accept.
// Stalls on downstream backpressure; inserts one bubble on a load-use hazard.
module decode_stage
    import mips_isa_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit HAZARD_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_dst,
    output logic [4:0]       out_shamt,
    output logic [XLEN-1:0]  out_imm,
    output logic [25:0]      out_instr_index,
    output logic [3:0]       out_alu_ctr,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_branch,
    output logic             out_jump,
    output logic             out_alu_src,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    decode_bundle_t  dec;
    decode_bundle_t  held;
    logic [XLEN-1:0] dec_imm;
    logic            uses_rs;
    logic            uses_rt;
    logic            hazard;
    logic            accept;

    decode_logic #(.XLEN(XLEN)) u_decode_logic (
        .instr   (in_instr),
        .dec     (dec),
        .imm     (dec_imm),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt)
    );

    // Only checked when the load is leaving this cycle; a stalled load blocks intake anyway.
    assign hazard = HAZARD_EN && in_valid && out_valid && out_ready &&
                    held.mem_read && (held.dst != 5'd0) &&
                    ((uses_rs && (dec.rs == held.dst)) || (uses_rt && (dec.rt == held.dst)));

    assign in_ready = rst_n && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            held      <= '0;
            out_pc    <= '0;
            out_imm   <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (hazard) begin
            out_valid <= 1'b0;
            if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (accept) begin
            out_valid <= 1'b1;
            held      <= dec;
            out_pc    <= in_pc;
            out_imm   <= dec_imm;
        end else if (out_ready && out_valid) begin
            out_valid <= 1'b0;
        end
    end

    assign out_rs          = held.rs;
    assign out_rt          = held.rt;
    assign out_dst         = held.dst;
    assign out_shamt       = held.shamt;
    assign out_instr_index = held.instr_index;
    assign out_alu_ctr     = held.alu_ctr;
    assign out_reg_write   = held.reg_write;
    assign out_mem_read    = held.mem_read;
    assign out_mem_write   = held.mem_write;
    assign out_branch      = held.branch;
    assign out_jump        = held.jump;
    assign out_alu_src     = held.alu_src;
    assign out_illegal     = held.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Drives three decode_stage variants (default, CNT_W=2, HAZARD_EN=0) with one
// stimulus stream and compares each against a mnemonic-level reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_ready = 1'b0;

    logic        o_rdy [3];
    logic        o_vld [3];
    logic [31:0] o_pc [3];
    logic [4:0]  o_rs [3];
    logic [4:0]  o_rt [3];
    logic [4:0]  o_dst [3];
    logic [4:0]  o_sh [3];
    logic [31:0] o_imm [3];
    logic [25:0] o_idx [3];
    logic [3:0]  o_alu [3];
    logic        o_rw [3];
    logic        o_mr [3];
    logic        o_mw [3];
    logic        o_br [3];
    logic        o_jp [3];
    logic        o_as [3];
    logic        o_ill [3];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;
    logic [15:0] cnt2;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .HAZARD_EN(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy[0]),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(o_vld[0]), .out_ready(out_ready),
        .out_pc(o_pc[0]), .out_rs(o_rs[0]), .out_rt(o_rt[0]), .out_dst(o_dst[0]),
        .out_shamt(o_sh[0]), .out_imm(o_imm[0]), .out_instr_index(o_idx[0]),
        .out_alu_ctr(o_alu[0]), .out_reg_write(o_rw[0]), .out_mem_read(o_mr[0]),
        .out_mem_write(o_mw[0]), .out_branch(o_br[0]), .out_jump(o_jp[0]),
        .out_alu_src(o_as[0]), .out_illegal(o_ill[0]), .stall_cnt(cnt0));

    decode_stage #(.XLEN(32), .HAZARD_EN(1'b1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy[1]),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(o_vld[1]), .out_ready(out_ready),
        .out_pc(o_pc[1]), .out_rs(o_rs[1]), .out_rt(o_rt[1]), .out_dst(o_dst[1]),
        .out_shamt(o_sh[1]), .out_imm(o_imm[1]), .out_instr_index(o_idx[1]),
        .out_alu_ctr(o_alu[1]), .out_reg_write(o_rw[1]), .out_mem_read(o_mr[1]),
        .out_mem_write(o_mw[1]), .out_branch(o_br[1]), .out_jump(o_jp[1]),
        .out_alu_src(o_as[1]), .out_illegal(o_ill[1]), .stall_cnt(cnt1));

    decode_stage #(.XLEN(32), .HAZARD_EN(1'b0), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy[2]),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(o_vld[2]), .out_ready(out_ready),
        .out_pc(o_pc[2]), .out_rs(o_rs[2]), .out_rt(o_rt[2]), .out_dst(o_dst[2]),
        .out_shamt(o_sh[2]), .out_imm(o_imm[2]), .out_instr_index(o_idx[2]),
        .out_alu_ctr(o_alu[2]), .out_reg_write(o_rw[2]), .out_mem_read(o_mr[2]),
        .out_mem_write(o_mw[2]), .out_branch(o_br[2]), .out_jump(o_jp[2]),
        .out_alu_src(o_as[2]), .out_illegal(o_ill[2]), .stall_cnt(cnt2));

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs, rt, dst, shamt;
        logic [25:0] idx;
        logic [3:0]  alu;
        logic        rw, mr, mw, br, jp, as_, ill;
        logic        skip;   // illegal opcode: alu_src/imm left unchecked
        logic        urs, urt;
    } bun_t;

    int   tests = 0;
    int   fails = 0;
    logic m_vld [3];
    bun_t m_b [3];
    int   m_cnt [3];
    logic m_rdy [3];
    logic m_haz [3];
    const logic haz_en [3] = '{1'b1, 1'b1, 1'b0};
    const int   cnt_max [3] = '{65535, 3, 65535};

    function automatic string mnem(input logic [31:0] i);
        case (i[31:26])
            6'h00: case (i[5:0])
                6'h00: return "SLL";   6'h02: return "SRL";  6'h03: return "SRA";
                6'h04: return "SLLV";  6'h06: return "SRLV"; 6'h07: return "SRAV";
                6'h20: return "ADD";   6'h21: return "ADDU"; 6'h22: return "SUB";
                6'h24: return "AND";   6'h25: return "OR";   6'h26: return "XOR";
                6'h27: return "NOR";   6'h2A: return "SLT";
                default: return "ILL";
            endcase
            6'h02: return "J";    6'h04: return "BEQ";  6'h08: return "ADDI";
            6'h0C: return "ANDI"; 6'h0D: return "ORI";  6'h0E: return "XORI";
            6'h23: return "LW";   6'h2B: return "SW";
            default: return "ILL";
        endcase
    endfunction

    function automatic bun_t ref_dec(input logic [31:0] i);
        bun_t  b;
        string m;
        logic  rty;
        m   = mnem(i);
        rty = (i[31:26] == 6'd0);
        b   = '0;
        b.rs = i[25:21]; b.rt = i[20:16]; b.shamt = i[10:6]; b.idx = i[25:0];
        b.dst  = rty ? i[15:11] : i[20:16];
        b.ill  = (m == "ILL");
        b.skip = b.ill && !rty;
        case (m)
            "SUB", "BEQ":          b.alu = 4'd1;
            "SRAV":                b.alu = 4'd3;
            "SLLV":                b.alu = 4'd4;
            "SLL":                 b.alu = 4'd5;
            "SLT":                 b.alu = 4'd7;
            "AND", "ANDI":         b.alu = 4'd9;
            "OR", "ORI":           b.alu = 4'd10;
            "SRA":                 b.alu = 4'd11;
            "NOR":                 b.alu = 4'd12;
            "XOR", "XORI":         b.alu = 4'd13;
            "SRLV":                b.alu = 4'd14;
            "SRL":                 b.alu = 4'd15;
            default:               b.alu = 4'd0;
        endcase
        case (m)
            "ADDI", "LW", "SW", "BEQ": b.imm = {{16{i[15]}}, i[15:0]};
            "ANDI", "ORI", "XORI":     b.imm = {16'd0, i[15:0]};
            default:                   b.imm = 32'd0;
        endcase
        b.rw  = (rty && !b.ill) || m == "ADDI" || m == "ANDI" || m == "ORI" ||
                m == "XORI" || m == "LW";
        b.mr  = (m == "LW");
        b.mw  = (m == "SW");
        b.br  = (m == "BEQ");
        b.jp  = (m == "J");
        b.as_ = !(rty || m == "BEQ") && !b.ill;
        b.urs = !(m == "J" || m == "SLL" || m == "SRL" || m == "SRA");
        b.urt = rty || m == "SW" || m == "BEQ";
        return b;
    endfunction

    function automatic logic [31:0] get_cnt(input int k);
        if (k == 0) return {16'd0, cnt0};
        if (k == 1) return {30'd0, cnt1};
        return {16'd0, cnt2};
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_fields(input int k, input bun_t e);
        chk("out_pc", k, o_pc[k], e.pc);
        chk("out_rs", k, {27'd0, o_rs[k]}, {27'd0, e.rs});
        chk("out_rt", k, {27'd0, o_rt[k]}, {27'd0, e.rt});
        chk("out_dst", k, {27'd0, o_dst[k]}, {27'd0, e.dst});
        chk("out_shamt", k, {27'd0, o_sh[k]}, {27'd0, e.shamt});
        chk("out_instr_index", k, {6'd0, o_idx[k]}, {6'd0, e.idx});
        chk("out_alu_ctr", k, {28'd0, o_alu[k]}, {28'd0, e.alu});
        chk("ctl{rw,mr,mw,br,jp,ill}", k,
            {26'd0, o_rw[k], o_mr[k], o_mw[k], o_br[k], o_jp[k], o_ill[k]},
            {26'd0, e.rw, e.mr, e.mw, e.br, e.jp, e.ill});
        if (!e.skip) begin
            chk("out_imm", k, o_imm[k], e.imm);
            chk("out_alu_src", k, {31'd0, o_as[k]}, {31'd0, e.as_});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h0022_1820; out_ready = 1'b1; flush = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            m_vld[k] = 1'b0; m_b[k] = '0; m_cnt[k] = 0;
            chk("in_ready_in_reset", k, {31'd0, o_rdy[k]}, 32'd0);
            chk("out_valid_reset", k, {31'd0, o_vld[k]}, 32'd0);
            chk("stall_cnt_reset", k, get_cnt(k), 32'd0);
            check_fields(k, '0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
    endtask

    task automatic cyc(input logic fl, input logic iv, input logic [31:0] ins,
                       input logic [31:0] pc, input logic ordy);
        bun_t d;
        @(negedge clk);
        flush = fl; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
        #1;
        d = ref_dec(ins);
        d.pc = pc;
        for (int k = 0; k < 3; k++) begin
            m_haz[k] = haz_en[k] && iv && m_vld[k] && ordy && m_b[k].mr && (m_b[k].dst != 5'd0) &&
                       ((d.urs && d.rs == m_b[k].dst) || (d.urt && d.rt == m_b[k].dst));
            m_rdy[k] = !fl && !m_haz[k] && (!m_vld[k] || ordy);
            chk("in_ready", k, {31'd0, o_rdy[k]}, {31'd0, m_rdy[k]});
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (fl) m_vld[k] = 1'b0;
            else if (m_haz[k]) begin
                m_vld[k] = 1'b0;
                if (m_cnt[k] < cnt_max[k]) m_cnt[k]++;
            end else if (iv && m_rdy[k]) begin
                m_vld[k] = 1'b1; m_b[k] = d;
            end else if (ordy && m_vld[k]) m_vld[k] = 1'b0;
            chk("out_valid", k, {31'd0, o_vld[k]}, {31'd0, m_vld[k]});
            chk("stall_cnt", k, get_cnt(k), m_cnt[k]);
            if (m_vld[k]) check_fields(k, m_b[k]);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [10];
        logic [5:0] fns [15];
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd;
        ops = '{6'h00, 6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
        fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h3F};
        op = ($urandom_range(0, 19) == 0) ? 6'h3F : ops[$urandom_range(0, 9)];
        if (op == 6'h23 && $urandom_range(0, 1) == 1) op = 6'h23;
        fn = fns[$urandom_range(0, 14)];
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        if (op == 6'h00) return {op, rs, rt, rd, 5'($urandom_range(0, 31)), fn};
        if (op == 6'h02) return {op, 26'($urandom())};
        return {op, rs, rt, 16'($urandom())};
    endfunction

    initial begin
        do_reset();

        // ADD $3,$1,$2
        cyc(1'b0, 1'b1, 32'h0022_1820, 32'h0000_0100, 1'b1);
        chk("add_valid", 0, {31'd0, o_vld[0]}, 32'd1);
        chk("add_alu", 0, {28'd0, o_alu[0]}, 32'd0);
        chk("add_dst", 0, {27'd0, o_dst[0]}, 32'd3);
        chk("add_rw_as", 0, {30'd0, o_rw[0], o_as[0]}, 32'b10);

        // ANDI / ADDI $5,$4,0x8001
        cyc(1'b0, 1'b1, 32'h3085_8001, 32'h0000_0104, 1'b1);
        chk("andi_imm", 0, o_imm[0], 32'h0000_8001);
        cyc(1'b0, 1'b1, 32'h2085_8001, 32'h0000_0108, 1'b1);
        chk("addi_imm", 0, o_imm[0], 32'hFFFF_8001);

        // LW $8,0($9) then dependent ADD $10,$8,$1
        cyc(1'b0, 1'b1, 32'h8D28_0000, 32'h0000_010C, 1'b1);
        cyc(1'b0, 1'b1, 32'h0101_5020, 32'h0000_0110, 1'b1);
        chk("bubble_valid", 0, {31'd0, o_vld[0]}, 32'd0);
        chk("nohaz_valid", 2, {31'd0, o_vld[2]}, 32'd1);
        cyc(1'b0, 1'b1, 32'h0101_5020, 32'h0000_0110, 1'b1);
        chk("dep_add_pc", 0, o_pc[0], 32'h0000_0110);
        chk("stall_cnt_one", 0, get_cnt(0), 32'd1);
        chk("nohaz_cnt", 2, get_cnt(2), 32'd0);

        // Backpressure: three stalled cycles, then release
        for (int n = 0; n < 3; n++) begin
            cyc(1'b0, 1'b1, 32'h0022_1820, 32'h0000_0200, 1'b0);
            chk("stall_pc_stable", 0, o_pc[0], 32'h0000_0110);
        end
        cyc(1'b0, 1'b1, 32'h0022_1820, 32'h0000_0200, 1'b1);
        chk("release_accept_pc", 0, o_pc[0], 32'h0000_0200);

        // Flush with a valid bundle and a valid input
        cyc(1'b1, 1'b1, 32'h3085_8001, 32'h0000_0204, 1'b0);
        chk("flush_valid", 0, {31'd0, o_vld[0]}, 32'd0);
        chk("flush_cnt", 0, get_cnt(0), 32'd1);

        // Illegal opcode and illegal funct
        cyc(1'b0, 1'b1, 32'hFC00_0000, 32'h0000_0300, 1'b1);
        chk("illop", 0, {26'd0, o_ill[0], o_rw[0], o_mw[0], o_br[0], o_jp[0], o_mr[0]}, 32'b100000);
        cyc(1'b0, 1'b1, 32'h0022_183F, 32'h0000_0304, 1'b1);
        chk("illfn", 0, {24'd0, o_ill[0], o_rw[0], o_mw[0], o_br[0], o_jp[0], o_alu[0], o_vld[0]}, 32'b1000000001);

        // Three more load-use pairs: 2-bit counter saturates at 3
        for (int n = 0; n < 3; n++) begin
            cyc(1'b0, 1'b1, 32'h8D28_0000, 32'h0000_0400, 1'b1);
            cyc(1'b0, 1'b1, 32'h0101_5020, 32'h0000_0404, 1'b1);
            cyc(1'b0, 1'b1, 32'h0101_5020, 32'h0000_0404, 1'b1);
        end
        chk("sat_cnt", 1, get_cnt(1), 32'd3);
        chk("wide_cnt", 0, get_cnt(0), 32'd4);

        // Reset while a bundle is held under backpressure
        cyc(1'b0, 1'b1, 32'h0022_1820, 32'h0000_0500, 1'b0);
        do_reset();

        for (int n = 0; n < 2000; n++) begin
            cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 8), rand_instr(),
                $urandom(), ($urandom_range(0, 9) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered instruction-decode pipeline stage (IF/ID → EX boundary) for the MIPS core.
- Decodes a 32-bit instruction into ALU control, datapath control, register indices and an extended immediate, and holds them in an output pipeline register.
- Uses a valid/ready handshake on both sides, supports flush, detects load-use hazards with automatic bubble insertion, and keeps a saturating stall counter.
- Sits between fetch and the ALU/execute block.

Parameters:
- XLEN, 32, datapath width; the immediate is extended to XLEN and the PC is XLEN wide.
- HAZARD_EN, 1, 1 = load-use detection and bubble insertion enabled; 0 = never stall.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  kill the held instruction; block intake this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  decoded bundle is valid.
- out_ready  in  1  execute consumes the bundle.
- out_pc  out  XLEN  registered PC.
- out_rs, out_rt  out  5 each  source register indices.
- out_dst  out  5  write destination: rd for R-type, rt otherwise.
- out_shamt  out  5  instr[10:6].
- out_imm  out  XLEN  extended imm16.
- out_instr_index  out  26  instr[25:0].
- out_alu_ctr  out  4  ALU operation.
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_alu_src  out  1 each  control bits.
- out_illegal  out  1  unsupported opcode/funct.
- stall_cnt  out  CNT_W  number of inserted load-use bubbles, saturating.

Behaviour:
- Reset: all outputs, including every out_* field, out_valid and stall_cnt, are 0.
- in_ready is 0 during reset.
- Latency: 1 cycle from acceptance (in_valid & in_ready) to out_valid.
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Register update priority, highest first:
  1. flush → out_valid <= 0.
  2. hazard → out_valid <= 0 (bubble), stall_cnt++.
  3. accept → load the decoded bundle, out_valid <= 1.
  4. out_ready & out_valid → out_valid <= 0.
  5. otherwise hold.
- Whenever out_valid & !out_ready, every out_* field is stable.
- hazard = HAZARD_EN & in_valid & out_valid & out_ready & out_mem_read & out_dst != 0 & (uses_rs & in.rs == out_dst | uses_rt & in.rt == out_dst).
- Effect of a hazard: the load advances, one bubble follows it, and the dependent instruction is accepted on the next cycle.
- uses_rs: all instructions except J, SLL, SRL, SRA.
- uses_rt: R-type, SW, BEQ.
- stall_cnt saturates at 2^CNT_W-1; it does not wrap.
- ALU encodings:
  - ADD/ADDU 0000, SUB 0001, SRAV 0011, SLLV 0100, SLL 0101, SLT 0111.
  - AND 1001, OR 1010, SRA 1011, NOR 1100, XOR 1101, SRLV 1110, SRL 1111.
  - Functs follow standard MIPS: SRL 000010, SRLV 000110, SRA 000011, SRAV 000111, SLLV 000100.
- I-type mapping: ADDI/LW/SW → ADD; ANDI → AND; ORI → OR; XORI → XOR; BEQ → SUB.
- Extension: sign-extend for ADDI, LW, SW, BEQ; zero-extend for ANDI, ORI, XORI; 0 for R-type and J.
- reg_write = 1 for R-type (legal), ADDI, ANDI, ORI, XORI, LW.
- alu_src = 0 for R-type and BEQ; 1 otherwise.
- Illegal opcode or R-type funct: out_illegal = 1, alu_ctr = 0000, and every write/mem/branch/jump control bit is 0. The bundle is still passed downstream with out_valid = 1.
- Decode logic is fully combinational; no latches. Every output has a defined default.
- Reset mid-handshake: the held bundle is discarded, and no acceptance happens during reset.

Decomposition:
- mips_isa_pkg holds:
  - opcode and funct localparams;
  - ALU_CTR_* encodings;
  - a decode bundle struct/width constant, shared with the ALU and the older combinational decoder.
- One sub-module, decode_logic: pure combinational instruction → bundle, plus the uses_rs/uses_rt flags. decode_stage wraps it with the pipeline register, hazard check and counter.

Test Plan:
- After reset, drive ADD $3,$1,$2 (0x00221820) with out_ready=1 → next cycle out_valid=1, alu_ctr=0000, out_dst=3, reg_write=1, alu_src=0.
- Drive ANDI $5,$4,0x8001 → out_imm=0x00008001. Drive ADDI $5,$4,0x8001 → out_imm=0xFFFF8001.
- Drive LW $8,0($9), then ADD $10,$8,$1 back-to-back → one bubble cycle (out_valid=0, in_ready=0), ADD appears the cycle after, stall_cnt=1. With HAZARD_EN=0 there is no bubble.
- Hold out_ready=0 for 3 cycles with a valid bundle → out fields stable, in_ready=0. Raise out_ready → next instruction accepted in the same cycle.
- Assert flush while out_valid=1 and in_valid=1 → next cycle out_valid=0, the input is not accepted, and stall_cnt is unchanged.
- Drive opcode 0x3F and R-type funct 0x3F → out_illegal=1, reg_write=mem_write=branch=jump=0. Also force stall_cnt to saturate (CNT_W=2, 4 hazards) → stall_cnt holds at 3.
